// File: rtl/memory_access_stage_if.sv
// Data-memory port between the MEM stage (master) and the data memory (slave).
// Handshake: MemReq/MemWe/MemAddr/MemWData are held stable while MemReq=1, and the cycle with MemAck=1 completes the request.
interface memory_access_stage_if;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic        MemAck;
  logic [31:0] MemRData;

  modport master (
    output MemReq, MemWe, MemAddr, MemWData,
    input  MemAck, MemRData
  );

  modport slave (
    input  MemReq, MemWe, MemAddr, MemWData,
    output MemAck, MemRData
  );
endinterface

// File: rtl/memory_access_stage.sv
// Pipeline MEM stage: issues loads/stores on a variable-latency memory port,
// stalls upstream while an access is outstanding, and registers the MEM/WB boundary.
module memory_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Valid,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ReadData2,
  input  logic [4:0]  RegDestAddress,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  memory_access_stage_if.master mem,
  output logic        Stall,
  output logic [31:0] WriteData,
  output logic [4:0]  WriteAddress,
  output logic        RegWrite_Out,
  output logic        Valid_Out,
  output logic        Error,
  output logic        DbgState
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} stateT;

  stateT         state;
  logic [CW-1:0] waitCnt;

  logic memOp;
  logic aligned;
  logic startReq;
  logic timeoutHit;

  assign memOp      = Valid && (MemRead || MemWrite);
  assign aligned    = (ALUResult[1:0] == 2'b00);
  assign startReq   = (state == IDLE) && memOp && aligned;
  assign timeoutHit = (state == ACCESS) && !mem.MemAck && (waitCnt == CW'(TIMEOUT));

  // Upstream holds EX/MEM stable while stalled, so the request fields can
  // come straight from the inputs; reset kills the request immediately.
  assign mem.MemReq   = Rst && (startReq || (state == ACCESS));
  assign mem.MemWe    = MemWrite;
  assign mem.MemAddr  = ALUResult;
  assign mem.MemWData = ReadData2;

  assign Stall    = mem.MemReq && !mem.MemAck && !timeoutHit;
  assign DbgState = (state == ACCESS);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state        <= IDLE;
      waitCnt      <= '0;
      Error        <= 1'b0;
      WriteData    <= '0;
      WriteAddress <= '0;
      RegWrite_Out <= 1'b0;
      Valid_Out    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!Valid) begin
            Valid_Out    <= 1'b0;
            RegWrite_Out <= 1'b0;
          end else if (!memOp) begin
            WriteData    <= ALUResult;
            WriteAddress <= RegDestAddress;
            RegWrite_Out <= RegWrite;
            Valid_Out    <= 1'b1;
          end else if (!aligned) begin
            Error        <= 1'b1;
            WriteData    <= ALUResult;
            WriteAddress <= RegDestAddress;
            RegWrite_Out <= 1'b0;
            Valid_Out    <= 1'b1;
          end else if (mem.MemAck) begin
            WriteData    <= MemtoReg ? mem.MemRData : ALUResult;
            WriteAddress <= RegDestAddress;
            RegWrite_Out <= RegWrite;
            Valid_Out    <= 1'b1;
          end else begin
            Valid_Out    <= 1'b0;
            RegWrite_Out <= 1'b0;
            waitCnt      <= CW'(1);
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem.MemAck) begin
            WriteData    <= MemtoReg ? mem.MemRData : ALUResult;
            WriteAddress <= RegDestAddress;
            RegWrite_Out <= RegWrite;
            Valid_Out    <= 1'b1;
            waitCnt      <= '0;
            state        <= IDLE;
          end else if (waitCnt == CW'(TIMEOUT)) begin
            // Abandon the access: the instruction retires without writeback.
            Error        <= 1'b1;
            WriteData    <= '0;
            WriteAddress <= RegDestAddress;
            RegWrite_Out <= 1'b0;
            Valid_Out    <= 1'b1;
            waitCnt      <= '0;
            state        <= IDLE;
          end else begin
            Valid_Out    <= 1'b0;
            RegWrite_Out <= 1'b0;
            waitCnt      <= waitCnt + CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          waitCnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: each instruction is expanded into its per-cycle
// expected outputs from the stage's rules, then compared on every falling edge.
module tb_memory_access_stage;
  localparam int TIMEOUT = 4;

  logic        Clk;
  logic        Rst;
  logic        Valid;
  logic [31:0] ALUResult;
  logic [31:0] ReadData2;
  logic [4:0]  RegDestAddress;
  logic        MemRead, MemWrite, MemtoReg, RegWrite;
  logic        Stall;
  logic [31:0] WriteData;
  logic [4:0]  WriteAddress;
  logic        RegWrite_Out, Valid_Out, Error, DbgState;

  memory_access_stage_if memBus ();

  memory_access_stage #(.TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Rst(Rst), .Valid(Valid), .ALUResult(ALUResult), .ReadData2(ReadData2),
    .RegDestAddress(RegDestAddress), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .mem(memBus), .Stall(Stall),
    .WriteData(WriteData), .WriteAddress(WriteAddress), .RegWrite_Out(RegWrite_Out),
    .Valid_Out(Valid_Out), .Error(Error), .DbgState(DbgState)
  );

  // clock/reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct packed {
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic        stall;
    logic        outValid;
    logic        outRw;
    logic [31:0] outWd;
    logic [4:0]  outWa;
    logic        chkWd;
    logic        chkWa;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t prevRec;
  exp_t curRec;
  bit   havePrev;
  bit   checking;
  bit   modelErr;
  int   checkCnt;
  int   passCnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic exp_t resetRec();
    exp_t r;
    r = '0;
    r.chkWd = 1'b1;
    r.chkWa = 1'b1;
    return r;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Driver: one instruction, held for as many cycles as the memory makes it wait.
  // ackDelay = stall cycles before MemAck; negative or > TIMEOUT = never acked.
  task automatic issue(input bit v, input bit rd, input bit wr, input bit m2r, input bit rw,
                       input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] dst,
                       input int ackDelay, input logic [31:0] ackData);
    bit   memOp, aligned, req, acked, last, ackNow;
    int   cycles;
    exp_t rec;
    memOp   = v && (rd || wr);
    aligned = (alu[1:0] == 2'b00);
    req     = memOp && aligned;
    acked   = (ackDelay >= 0) && (ackDelay <= TIMEOUT);
    if (!req) cycles = 1;
    else if (acked) cycles = ackDelay + 1;
    else cycles = TIMEOUT + 1;
    for (int c = 0; c < cycles; c++) begin
      last   = (c == cycles - 1);
      ackNow = req && acked && last;
      Valid = v; MemRead = rd; MemWrite = wr; MemtoReg = m2r; RegWrite = rw;
      ALUResult = alu; ReadData2 = sd; RegDestAddress = dst;
      memBus.MemAck   = req ? ackNow : ($urandom_range(0, 3) == 0);
      memBus.MemRData = ackNow ? ackData : $urandom;
      rec = '0;
      rec.memReq   = req;
      rec.memWe    = wr;
      rec.memAddr  = alu;
      rec.memWData = sd;
      rec.stall    = req && !last;
      if (v) begin
        if (!memOp) begin
          rec.outValid = 1'b1; rec.outRw = rw; rec.outWd = alu; rec.outWa = dst;
          rec.chkWd = 1'b1; rec.chkWa = 1'b1;
        end else if (!aligned) begin
          rec.outValid = 1'b1;
          modelErr = 1'b1;
        end else if (last && ackNow) begin
          rec.outValid = 1'b1; rec.outRw = rw; rec.outWd = m2r ? ackData : alu; rec.outWa = dst;
          rec.chkWd = 1'b1; rec.chkWa = 1'b1;
        end else if (last) begin
          rec.outValid = 1'b1; rec.outWd = 32'h0; rec.chkWd = 1'b1;
          modelErr = 1'b1;
        end
      end
      rec.err = modelErr;
      exp_q.push_back(rec);
      step();
    end
  endtask

  task automatic startChecking();
    prevRec  = resetRec();
    havePrev = 1'b1;
    checking = 1'b1;
  endtask

  task automatic drainChecking();
    @(negedge Clk);
    #1;
    checking = 1'b0;
  endtask

  // Scoreboard: combinational outputs of this cycle, registered outputs of the last edge.
  always @(negedge Clk) begin
    if (checking) begin
      if (havePrev) begin
        check("Valid_Out", 32'(Valid_Out), 32'(prevRec.outValid));
        check("RegWrite_Out", 32'(RegWrite_Out), 32'(prevRec.outRw));
        check("Error", 32'(Error), 32'(prevRec.err));
        if (prevRec.chkWd) check("WriteData", WriteData, prevRec.outWd);
        if (prevRec.chkWa) check("WriteAddress", 32'(WriteAddress), 32'(prevRec.outWa));
      end
      if (exp_q.size() > 0) begin
        curRec = exp_q.pop_front();
        check("MemReq", 32'(memBus.MemReq), 32'(curRec.memReq));
        check("Stall", 32'(Stall), 32'(curRec.stall));
        if (curRec.memReq) begin
          check("MemWe", 32'(memBus.MemWe), 32'(curRec.memWe));
          check("MemAddr", memBus.MemAddr, curRec.memAddr);
          check("MemWData", memBus.MemWData, curRec.memWData);
        end
        prevRec  = curRec;
        havePrev = 1'b1;
      end else begin
        havePrev = 1'b0;
      end
    end
  end

  initial begin
    logic [31:0] alu;
    int          r, kind, dly;
    checkCnt = 0; passCnt = 0; checking = 1'b0; havePrev = 1'b0; modelErr = 1'b0;
    Rst = 1'b0; Valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0;
    ALUResult = '0; ReadData2 = '0; RegDestAddress = '0;
    memBus.MemAck = 1'b0; memBus.MemRData = '0;
    repeat (3) step();
    check("reset Valid_Out", 32'(Valid_Out), 32'd0);
    check("reset WriteData", WriteData, 32'd0);
    check("reset Error", 32'(Error), 32'd0);
    check("reset DbgState", 32'(DbgState), 32'd0);
    Rst = 1'b1;
    startChecking();

    // Directed cases with literal expectations.
    issue(1, 0, 0, 0, 1, 32'h5, 32'h0, 5'd9, 0, 32'h0);
    check("nonmem WriteData", WriteData, 32'h5);
    check("nonmem WriteAddress", 32'(WriteAddress), 32'd9);
    check("nonmem RegWrite_Out", 32'(RegWrite_Out), 32'd1);
    issue(1, 1, 0, 1, 1, 32'h10, 32'h0, 5'd3, 3, 32'hDEADBEEF);
    check("load WriteData", WriteData, 32'hDEADBEEF);
    check("load RegWrite_Out", 32'(RegWrite_Out), 32'd1);
    issue(1, 0, 1, 0, 0, 32'h20, 32'h12345678, 5'd0, 0, 32'h0);
    check("store Valid_Out", 32'(Valid_Out), 32'd1);
    check("store RegWrite_Out", 32'(RegWrite_Out), 32'd0);
    issue(1, 1, 0, 1, 1, 32'h40, 32'h0, 5'd7, TIMEOUT, 32'hCAFEF00D);
    check("late ack WriteData", WriteData, 32'hCAFEF00D);
    check("late ack Error", 32'(Error), 32'd0);
    issue(1, 1, 1, 0, 1, 32'h44, 32'hA5A5A5A5, 5'd8, 1, 32'h0);
    check("rd+wr WriteData", WriteData, 32'h44);
    issue(1, 1, 0, 1, 1, 32'h13, 32'h0, 5'd4, 0, 32'h0);
    check("misaligned Error", 32'(Error), 32'd1);
    check("misaligned RegWrite_Out", 32'(RegWrite_Out), 32'd0);
    issue(1, 0, 0, 0, 1, 32'h77, 32'h0, 5'd2, 0, 32'h0);
    check("after misaligned WriteData", WriteData, 32'h77);
    issue(1, 1, 0, 1, 1, 32'h80, 32'h0, 5'd6, -1, 32'h0);
    check("timeout WriteData", WriteData, 32'h0);
    check("timeout Valid_Out", 32'(Valid_Out), 32'd1);
    check("timeout RegWrite_Out", 32'(RegWrite_Out), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      alu  = $urandom;
      if ($urandom_range(0, 6) != 0) alu[1:0] = 2'b00;
      r    = $urandom_range(0, TIMEOUT + 2);
      dly  = (r > TIMEOUT) ? -1 : r;
      if (kind == 0)
        issue(0, $urandom_range(0, 1), $urandom_range(0, 1), 1'b0, 1'b1, alu, $urandom, 5'($urandom), dly, $urandom);
      else if (kind < 4)
        issue(1, 0, 0, $urandom_range(0, 1), $urandom_range(0, 1), alu, $urandom, 5'($urandom), dly, $urandom);
      else
        issue(1, $urandom_range(0, 1), $urandom_range(0, 1) | (kind > 6), $urandom_range(0, 1),
              $urandom_range(0, 1), alu, $urandom, 5'($urandom), dly, $urandom);
    end
    drainChecking();

    // Asynchronous reset in the middle of an access.
    @(posedge Clk); #1;
    Valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; MemtoReg = 1'b1; RegWrite = 1'b1;
    ALUResult = 32'h100; RegDestAddress = 5'd5; memBus.MemAck = 1'b0;
    step();
    step();
    check("pre-reset DbgState", 32'(DbgState), 32'd1);
    #2;
    Rst = 1'b0;
    #1;
    check("reset MemReq", 32'(memBus.MemReq), 32'd0);
    check("reset Stall", 32'(Stall), 32'd0);
    check("reset DbgState mid", 32'(DbgState), 32'd0);
    check("reset Error mid", 32'(Error), 32'd0);
    check("reset WriteAddress mid", 32'(WriteAddress), 32'd0);
    check("reset RegWrite_Out mid", 32'(RegWrite_Out), 32'd0);
    Valid = 1'b0; MemRead = 1'b0;
    step();
    Rst = 1'b1;
    modelErr = 1'b0;
    exp_q.delete();
    startChecking();
    issue(1, 0, 0, 0, 1, 32'h33, 32'h0, 5'd1, 0, 32'h0);
    issue(1, 1, 0, 1, 1, 32'h200, 32'h0, 5'd2, 1, 32'h0BADF00D);
    check("post-reset load WriteData", WriteData, 32'h0BADF00D);
    drainChecking();

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end
endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Pipeline MEM stage: the consumer of the Execution stage's outputs. It takes the ALU result, store data, destination register and memory/writeback control bits from the EX/MEM boundary. It performs load/store transactions on a variable-latency data-memory port with a request/acknowledge handshake, stalling upstream while a transaction is outstanding. It then drives the registered MEM/WB boundary consumed by writeback.

## Interface
- TIMEOUT, 16: max cycles to wait for MemAck before aborting an access (≥1).
- Clk  in  1  clock; all state changes on rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Valid  in  1  EX/MEM holds a real instruction (0 = bubble).
- ALUResult  in  32  ALU low result; memory byte address for loads/stores.
- ReadData2  in  32  store data.
- RegDestAddress  in  5  destination register.
- MemRead, MemWrite, MemtoReg, RegWrite  in  1 each  control bits from EX.
- MemReq  out  1  memory request.
- MemWe  out  1  1 = store, 0 = load; valid with MemReq.
- MemAddr  out  32  word-aligned address = ALUResult; valid with MemReq.
- MemWData  out  32  = ReadData2; valid with MemReq.
- MemAck  in  1  memory completes the current request this cycle.
- MemRData  in  32  load data; valid when MemAck=1.
- Stall  out  1  combinational; upstream must hold EX/MEM inputs stable while 1.
- WriteData  out  32  registered: MemtoReg ? load data : ALUResult.
- WriteAddress  out  5  registered RegDestAddress.
- RegWrite_Out  out  1  registered writeback enable.
- Valid_Out  out  1  registered; MEM/WB holds a real instruction.
- Error  out  1  sticky: misaligned access or timeout; cleared only by reset.

## Operation
- FSM states: IDLE, ACCESS.
- IDLE, Valid=0: MEM/WB loads bubble (Valid_Out=0, RegWrite_Out=0); Stall=0.
- IDLE, Valid=1, MemRead=MemWrite=0: MEM/WB loads ALUResult, RegDestAddress, RegWrite; Valid_Out=1; Stall=0.
- IDLE, Valid=1, MemRead|MemWrite, ALUResult[1:0]≠0: no request; Error set; MEM/WB loads Valid_Out=1, RegWrite_Out=0; Stall=0.
- IDLE, aligned memory op: MemReq=1 combinationally, with MemWe=MemWrite.
  - MemAck=1 same cycle: completes, remains IDLE, Stall=0.
  - MemAck=0: Stall=1, MEM/WB loads bubble, go ACCESS, wait counter := 1.
- ACCESS: MemReq held with stable MemWe/MemAddr/MemWData.
  - MemAck=1: complete, Stall=0, go IDLE.
  - MemAck=0 and counter=TIMEOUT: abort, Error set, MemReq drops next cycle, MEM/WB loads Valid_Out=1, RegWrite_Out=0, WriteData=0, Stall=0, go IDLE.
  - Otherwise: Stall=1, counter+1, MEM/WB loads bubble.
- Completion: MEM/WB loads WriteData = MemtoReg ? MemRData : ALUResult, WriteAddress, RegWrite_Out=RegWrite, Valid_Out=1.
- MemRead and MemWrite both 1: treated as store.
- MemAck while MemReq=0: ignored.

## Timing
- Reset (Rst=0, async): state IDLE, counter 0, Error 0, WriteData 0, WriteAddress 0, RegWrite_Out 0, Valid_Out 0. MemReq and Stall go to 0 immediately, even mid-access; an outstanding request is abandoned.
- Non-memory op latency: 1 cycle, input to MEM/WB.
- Load/store latency: 1 cycle plus the number of cycles until MemAck. Zero-wait ack is 1 cycle.
- Stall is deasserted in the MemAck cycle, so upstream advances on the same edge MEM/WB captures the result. There are no dead cycles between back-to-back accesses.
- Timeout fires on the TIMEOUT-th ACCESS cycle without ack. A MemAck arriving in that same cycle wins over the timeout.

## Test plan
- Reset with outputs pre-loaded, Rst=0 mid-ACCESS -> MemReq=0 and Stall=0 immediately; all registered outputs 0; state IDLE after release.
- Non-memory op: ALUResult=0x00000005, RegDest=9, RegWrite=1 -> next edge WriteData=5, WriteAddress=9, RegWrite_Out=1, Valid_Out=1, MemReq never high.
- Load at 0x00000010, MemtoReg=1, MemAck after 3 cycles with MemRData=0xDEADBEEF -> Stall high 3 cycles, bubbles out, then WriteData=0xDEADBEEF, RegWrite_Out=1.
- Store at 0x00000020, ReadData2=0x12345678, zero-wait ack -> MemReq=1, MemWe=1, MemWData=0x12345678 for 1 cycle; Stall never high; RegWrite_Out=0.
- Misaligned load at 0x00000013 -> no MemReq; Error=1 sticky; Valid_Out=1, RegWrite_Out=0; subsequent ops unaffected.
- TIMEOUT=4, load never acked -> Stall high 4 cycles, then Error=1, WriteData=0, RegWrite_Out=0; repeat with MemAck in the 4th cycle -> normal completion, Error stays 0.
